his_frame_scheduler: RTL and testbench

//  Sequences TDC bin samples into a ping-pong (2-bank) histogram RAM and owns bank ownership.

---
 rtl/his_frame_scheduler.sv | 98 +++++++++
 tb/tb_his_frame_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/his_frame_scheduler.sv
// his_frame_scheduler: ping-pong histogram bank sequencer that clears the write bank, accumulates
// TDC samples into it and hands each finished bank to the peak finder.
module his_frame_scheduler #(
   parameter int BIN_W     = 10,
   parameter int DATA_NUM  = 2,
   parameter int PIX_NUM   = 200,
   parameter int ACQ_NUM   = 33333,
   parameter int CLR_DEPTH = 1024,
   localparam int PIX_W    = $clog2(PIX_NUM),
   localparam int CLR_AW   = $clog2(CLR_DEPTH)
) (
   input  logic              clk,
   input  logic              res,
   input  logic              in_valid,
   input  logic [BIN_W-1:0]  in_bin,
   output logic              in_ready,
   output logic              wr_en,
   output logic [PIX_W-1:0]  wr_pix,
   output logic [BIN_W-1:0]  wr_bin,
   output logic              wr_bank,
   output logic              clr_en,
   output logic [CLR_AW-1:0] clr_addr,
   output logic              frame_done,
   output logic              rd_bank,
   output logic              rd_busy,
   input  logic              rd_ack
);
   localparam int INP_W = DATA_NUM > 1 ? $clog2(DATA_NUM) : 1;
   localparam int ACQ_W = ACQ_NUM > 1 ? $clog2(ACQ_NUM) : 1;
   typedef enum logic [1:0] {CLEAR, ACCUM, HANDOFF} state_t;
   state_t state, state_nx;
   logic armed, hs, inp_last, pix_last, acq_last, clr_last;
   logic [INP_W-1:0]  inp_cnt;
   logic [PIX_W-1:0]  pix_cnt;
   logic [ACQ_W-1:0]  acq_cnt;
   logic [CLR_AW-1:0] clr_cnt;
   assign inp_last = inp_cnt == INP_W'(DATA_NUM - 1);
   assign pix_last = pix_cnt == PIX_W'(PIX_NUM - 1);
   assign acq_last = acq_cnt == ACQ_W'(ACQ_NUM - 1);
   assign clr_last = clr_cnt == CLR_AW'(CLR_DEPTH - 1);
   assign hs       = in_valid && in_ready;
   assign clr_addr = clr_cnt;
   always_ff @(posedge clk or negedge res)
      if (!res) state <= CLEAR;
      else      state <= state_nx;
   // armed keeps clr_en low while reset is held, since CLEAR is also the reset state
   always_comb begin
      state_nx   = state;
      in_ready   = 1'b0;
      clr_en     = 1'b0;
      frame_done = 1'b0;
      case (state)
         CLEAR: begin
            clr_en = armed;
            if (armed && clr_last) state_nx = ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && inp_last && pix_last && acq_last) state_nx = HANDOFF;
         end
         HANDOFF: begin
            frame_done = !rd_busy || rd_ack;
            if (frame_done) state_nx = CLEAR;
         end
         default: state_nx = CLEAR;
      endcase
   end
   always_ff @(posedge clk or negedge res)
      if (!res) begin
         armed   <= 1'b0;
         clr_cnt <= '0;
         inp_cnt <= '0;
         pix_cnt <= '0;
         acq_cnt <= '0;
         wr_en   <= 1'b0;
         wr_pix  <= '0;
         wr_bin  <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         rd_busy <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (clr_en) clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
         wr_en <= hs;
         if (hs) begin
            wr_pix  <= pix_cnt;
            wr_bin  <= in_bin;
            inp_cnt <= inp_last ? '0 : inp_cnt + 1'b1;
            if (inp_last) pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
            if (inp_last && pix_last) acq_cnt <= acq_last ? '0 : acq_cnt + 1'b1;
         end
         if (frame_done) begin
            rd_bank <= wr_bank;
            wr_bank <= ~wr_bank;
         end
         rd_busy <= frame_done || (rd_busy && !rd_ack);
      end
endmodule

// File: tb/tb_his_frame_scheduler.sv
// tb_his_frame_scheduler: randomized scoreboard bench; a frame-level model predicts every
// write command and bank handoff.
module tb_his_frame_scheduler;
   localparam int DN = 2, PN = 3, AN = 2, CD = 4, BW = 4;
   localparam int FRAME = DN * PN * AN;
   logic clk = 1'b0, res = 1'b0, in_valid = 1'b0, rd_ack = 1'b0;
   logic [BW-1:0] in_bin = '0;
   logic in_ready, wr_en, wr_bank, clr_en, frame_done, rd_bank, rd_busy;
   logic [1:0] wr_pix, clr_addr;
   logic [BW-1:0] wr_bin;
   logic [15:0] outs;
   logic [6:0] q[$];
   logic [6:0] e;
   int checks = 0, errors = 0, k = 0, f = 0, tgt;
   int cidx, wcnt, fdn;
   logic pend, exp_rb, prev_ack, prev_fd;
   his_frame_scheduler #(.BIN_W(BW), .DATA_NUM(DN), .PIX_NUM(PN), .ACQ_NUM(AN), .CLR_DEPTH(CD)) dut (
      .clk(clk), .res(res), .in_valid(in_valid), .in_bin(in_bin), .in_ready(in_ready),
      .wr_en(wr_en), .wr_pix(wr_pix), .wr_bin(wr_bin), .wr_bank(wr_bank), .clr_en(clr_en),
      .clr_addr(clr_addr), .frame_done(frame_done), .rd_bank(rd_bank), .rd_busy(rd_busy),
      .rd_ack(rd_ack));
   always #5 clk = ~clk;
   assign outs = {wr_en, wr_pix, wr_bin, wr_bank, clr_en, clr_addr, frame_done, rd_bank, rd_busy, in_ready};
   task automatic chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   // Accepted sample n of a frame lands on pixel (n / DATA_NUM) mod PIX_NUM of bank frame mod 2.
   task automatic drive(input logic v, input logic [BW-1:0] b, input logic ack);
      @(posedge clk);
      #1;
      in_valid = v;
      in_bin   = b;
      rd_ack   = ack;
      @(negedge clk);
      if (v && in_ready && res) begin
         q.push_back({1'(f % 2), 2'((k / DN) % PN), b});
         k++;
         if (k == FRAME) begin
            k = 0;
            f++;
         end
      end
   endtask
   task automatic wait_ready(input logic ack);
      int n = 0;
      while (!in_ready && n < 100) begin
         drive(1'($urandom), 4'($urandom), ack);
         n++;
      end
      chk(in_ready, "ready_timeout", int'(in_ready), 1);
   endtask
   task automatic model_reset();
      q.delete();
      k = 0;
      f = 0;
   endtask
   always @(negedge clk) begin
      if (!res) begin
         cidx = 0; wcnt = 0; fdn = 0; pend = 0; prev_ack = 0; prev_fd = 0;
      end else begin
         if (pend) begin
            chk(rd_bank == exp_rb, "rd_bank", int'(rd_bank), int'(exp_rb));
            chk(wr_bank == !exp_rb, "wr_bank_flip", int'(wr_bank), int'(!exp_rb));
            chk(rd_busy, "rd_busy_set", int'(rd_busy), 1);
            pend = 0;
         end else if (prev_ack && !prev_fd) chk(!rd_busy, "rd_busy_ack", int'(rd_busy), 0);
         if (wr_en) begin
            chk(!clr_en, "wr_clr_excl", int'(clr_en), 0);
            if (q.size() == 0) chk(1'b0, "wr_unexpected", int'({wr_bank, wr_pix, wr_bin}), -1);
            else begin
               e = q.pop_front();
               chk({wr_bank, wr_pix, wr_bin} == e, "wr_cmd", int'({wr_bank, wr_pix, wr_bin}), int'(e));
            end
            wcnt++;
         end
         if (clr_en) begin
            chk(clr_addr == 2'(cidx), "clr_addr", int'(clr_addr), cidx);
            chk(wr_bank == 1'(f % 2), "clr_bank", int'(wr_bank), f % 2);
            chk(!in_ready, "clr_ready", int'(in_ready), 0);
            cidx++;
         end else if (cidx != 0) begin
            chk(cidx == CD, "clr_len", cidx, CD);
            cidx = 0;
         end
         if (frame_done) begin
            chk(wcnt == FRAME, "frame_writes", wcnt, FRAME);
            wcnt   = 0;
            exp_rb = 1'(fdn % 2);
            fdn++;
            pend = 1;
         end
         prev_ack = rd_ack;
         prev_fd  = frame_done;
      end
   end
   initial begin
      #1;
      chk(outs == 0, "reset_outs", int'(outs), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         chk(outs == 0, "reset_hold", int'(outs), 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      res = 1'b1;
      wait_ready(1'b0);
      for (int i = 0; i < FRAME; i++) drive(1'b1, 4'(i), 1'b0);
      drive(1'b0, '0, 1'b0);
      chk(frame_done, "fd_free", int'(frame_done), 1);
      wait_ready(1'b0);
      for (int i = 0; i < FRAME; i++) drive(1'b1, 4'($urandom), 1'b0);
      for (int i = 0; i < 8; i++) begin
         drive(1'($urandom), 4'($urandom), 1'b0);
         chk(!in_ready && !frame_done, "handoff_stall", int'({in_ready, frame_done}), 0);
      end
      drive(1'b0, '0, 1'b1);
      chk(frame_done, "fd_on_ack", int'(frame_done), 1);
      wait_ready(1'b0);
      for (int i = 0; i < FRAME; i++) drive(1'b1, 4'($urandom), 1'b0);
      drive(1'b0, '0, 1'b1);
      chk(frame_done, "fd_same_cycle_ack", int'(frame_done), 1);
      drive(1'b0, '0, 1'b0);
      chk(rd_busy, "busy_set_wins", int'(rd_busy), 1);
      tgt = f + 3;
      for (int n = 0; n < 3000 && f < tgt; n++)
         drive(1'($urandom), 4'($urandom), $urandom_range(5) == 0);
      chk(f >= tgt, "random_progress", f, tgt);
      wait_ready(1'b1);
      for (int i = 0; i < DN * PN + DN; i++) drive(1'b1, 4'($urandom), 1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      #1;
      res = 1'b0;
      model_reset();
      #1;
      chk(outs == 0, "mid_frame_reset", int'(outs), 0);
      @(negedge clk);
      res = 1'b1;
      wait_ready(1'b0);
      drive(1'b1, 4'd5, 1'b0);
      drive(1'b1, 4'd9, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0);
      chk(q.size() == 0, "queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
